prv32_muldiv_unit: RTL and testbench
====================================

// Module: prv32_muldiv_unit
// PURPOSE
//  Multi-cycle RV32M execute unit with a valid/ready handshake. Next generation of the combinational ALU M-ops.
//  Width-parametrised. Iterative divider with RISC-V div-by-zero/overflow semantics, flushable mid-op.
//  Sits beside prv32_ALU in EX; the core stalls while a M-op is in flight.
// PARAMETERS
//  XLEN      32  operand/result width (>=8, even)
//  MUL_REG   1   1: register product before result mux (MUL latency 2); 0: latency 1
// PORTS
//  clk        in   1     system clock, rising edge
//  rst        in   1     asynchronous, active-high reset
//  in_valid   in   1     operation request
//  in_ready   out  1     unit can accept (state IDLE)
//  op         in   3     funct3: 000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  a, b       in   XLEN  rs1, rs2 operands (sampled on accept only)
//  flush      in   1     kill in-flight op (branch/trap); no result produced
//  out_valid  out  1     result valid; held until out_ready
//  out_ready  in   1     consumer takes result
//  result     out  XLEN  result; stable while out_valid
//  busy       out  1     op in flight or result pending (= ~in_ready)
// BEHAVIOUR
//  - One clock, clk; reset rst is asynchronous and active-high. On rst: state=IDLE, in_ready=1, out_valid=0,
//    result=0, busy=0, counter=0. rst mid-operation discards the op without any output.
//  - Accept: rising edge with in_valid&&in_ready. op/a/b latched; in_ready drops the next cycle.
//  - FSM: IDLE -> MUL | DIV | DONE(special); MUL -> DONE; DIV -> DIV while cnt!=0, -> FIX; FIX -> DONE;
//    DONE -> IDLE when out_ready. DONE drives out_valid=1.
//  - Latency from the accept cycle k: MUL-class out_valid in cycle k+1+MUL_REG.
//    DIV-class in k+XLEN+2 (XLEN iterations + sign fix). Special cases in k+1.
//  - MUL: 2*XLEN product of sign-extended operands. a signed for MULH/MULHSU; b signed for MULH only.
//    MUL returns [XLEN-1:0]; the others return [2XLEN-1:XLEN].
//  - DIV: restoring radix-2 on magnitudes, 1 quotient bit/cycle, cnt counts XLEN-1..0.
//    Signed: quotient negated iff sign(a)!=sign(b); remainder takes sign(a). Fix applied in FIX.
//  - b==0: DIV/DIVU -> all ones; REM/REMU -> a.
//  - Signed overflow (a==MIN, b==-1) for DIV -> MIN, REM -> 0.
//  - No X or exception ever.
//  - flush: any state -> IDLE next cycle, out_valid=0, in_ready=1 next cycle.
//    flush overrides a same-cycle out_ready handshake and drops the result.
//    flush with in_valid in IDLE: flush wins, nothing is accepted.
//  - out_valid&&out_ready in DONE with in_valid: the new op is NOT accepted that cycle (in_ready=0).
//    It is accepted the following cycle.
//  - result/out_valid never change while out_valid=1&&out_ready=0 (stall-stable).
//  - a/b changing after accept has no effect.
// STRUCTURE
//  - Add `MD_MUL..`MD_REMU funct3 macros and state encodings to defines.v; use nowhere else.
//  - One sub-module: prv32_div_iter (iterative restoring divider core).
//    Ports: clk, rst, start, kill, dividend, divisor magnitudes, quotient, remainder, done.
//  - Top holds FSM, special-case detect, sign fix, multiplier, output register.
// TESTING
//  1 MUL a=7 b=-3 -> 0xFFFFFFEB; MULH a=0x80000000 b=0x80000000 -> 0x40000000; MULHU -1*-1 -> 0xFFFFFFFE.
//    out_valid at k+2 each.
//  2 DIV a=-20 b=3 -> 0xFFFFFFFA; REM -> 0xFFFFFFFE; DIVU 100/7 -> 14; out_valid exactly at k+34.
//  3 DIV/REMU b=0 a=0x1234 -> 0xFFFFFFFF / 0x1234; DIV 0x80000000/-1 -> 0x80000000, REM -> 0.
//    All at k+1.
//  4 DIV accepted, flush at k+10 -> no out_valid ever, in_ready=1 at k+11; new MUL 3*5 -> 15.
//  5 Result held with out_ready=0 for 5 cycles -> result/out_valid stable; back-to-back ops after release.
//  6 rst asserted asynchronously mid-DIV -> outputs at reset values immediately; XLEN=16 DIV -5/2 -> 0xFFFE.

Source files
------------

// File: rtl/prv32_muldiv_unit_pkg.sv
// rtl/prv32_muldiv_unit_pkg.sv - RV32M funct3 codes, FSM states and op-class helpers
package prv32_muldiv_unit_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } md_state_e;

  function automatic logic md_is_div(input logic [2:0] f);
    return (f == MD_DIV) || (f == MD_DIVU) || (f == MD_REM) || (f == MD_REMU);
  endfunction

  function automatic logic md_is_rem(input logic [2:0] f);
    return (f == MD_REM) || (f == MD_REMU);
  endfunction

  function automatic logic md_div_signed(input logic [2:0] f);
    return (f == MD_DIV) || (f == MD_REM);
  endfunction

  function automatic logic md_a_signed(input logic [2:0] f);
    return (f == MD_MULH) || (f == MD_MULHSU);
  endfunction

  function automatic logic md_b_signed(input logic [2:0] f);
    return (f == MD_MULH);
  endfunction

endpackage

// File: rtl/prv32_div_iter.sv
// rtl/prv32_div_iter.sv - restoring radix-2 unsigned divider, one quotient bit per cycle
module prv32_div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            done
);

  localparam int CW = $clog2(XLEN);

  logic [CW-1:0]   cnt;
  logic            active;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] dvs_q;
  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] diff;
  logic            ge;

  // Dividend bits shift out of the quotient register into the partial remainder.
  assign shifted = {rem_q, quo_q[XLEN-1]};
  assign ge      = shifted >= {1'b0, dvs_q};
  assign diff    = shifted[XLEN-1:0] - dvs_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      active <= 1'b0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
    end else if (kill) begin
      cnt    <= '0;
      active <= 1'b0;
    end else if (start) begin
      cnt    <= CW'(XLEN - 1);
      active <= 1'b1;
      rem_q  <= '0;
      quo_q  <= dividend;
      dvs_q  <= divisor;
    end else if (active) begin
      rem_q <= ge ? diff : shifted[XLEN-1:0];
      quo_q <= {quo_q[XLEN-2:0], ge};
      if (cnt == '0) active <= 1'b0;
      else           cnt    <= cnt - CW'(1);
    end
  end

  // High during the final iteration; results are valid from the next cycle.
  assign done      = active && (cnt == '0);
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/prv32_muldiv_unit.sv
// rtl/prv32_muldiv_unit.sv - multi-cycle RV32M execute unit with valid/ready handshake
module prv32_muldiv_unit
  import prv32_muldiv_unit_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MUL_REG = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e         state_q, state_d;
  logic              accept;
  logic [2:0]        op_q;
  logic              q_neg_q, r_neg_q;
  logic [XLEN-1:0]   result_q;
  logic [2*XLEN-1:0] ax, bx, product, mul_src;
  logic              a_neg, b_neg, div_by_zero, overflow, special;
  logic [XLEN-1:0]   a_mag, b_mag, special_res, fixed_res;
  logic [XLEN-1:0]   div_quo, div_rem;
  logic              div_done;

  function automatic logic [XLEN-1:0] mul_pick(input logic [2*XLEN-1:0] p, input logic [2:0] f);
    return (f == MD_MUL) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  assign accept = in_valid && in_ready && !flush;

  assign ax      = {{XLEN{md_a_signed(op) & a[XLEN-1]}}, a};
  assign bx      = {{XLEN{md_b_signed(op) & b[XLEN-1]}}, b};
  assign product = ax * bx;

  generate
    if (MUL_REG != 0) begin : g_mul_reg
      logic [2*XLEN-1:0] prod_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)         prod_q <= '0;
        else if (accept) prod_q <= product;
      end
      assign mul_src = prod_q;
    end else begin : g_mul_comb
      assign mul_src = product;
    end
  endgenerate

  // Divider runs on magnitudes; signs are restored in FIX.
  assign a_neg       = md_div_signed(op) & a[XLEN-1];
  assign b_neg       = md_div_signed(op) & b[XLEN-1];
  assign a_mag       = a_neg ? -a : a;
  assign b_mag       = b_neg ? -b : b;
  assign div_by_zero = (b == '0);
  assign overflow    = md_div_signed(op) && (a == XMIN) && (b == '1);
  assign special     = div_by_zero || overflow;
  assign special_res = div_by_zero ? (md_is_rem(op) ? a : '1) : (md_is_rem(op) ? '0 : XMIN);

  prv32_div_iter #(.XLEN(XLEN)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (accept && md_is_div(op) && !special),
    .kill      (flush),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .quotient  (div_quo),
    .remainder (div_rem),
    .done      (div_done)
  );

  assign fixed_res = md_is_rem(op_q) ? (r_neg_q ? -div_rem : div_rem)
                                     : (q_neg_q ? -div_quo : div_quo);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    busy      = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: if (accept) begin
        if (md_is_div(op)) state_d = special ? ST_DONE : ST_DIV;
        else               state_d = (MUL_REG != 0) ? ST_MUL : ST_DONE;
      end
      ST_MUL:  state_d = ST_DONE;
      ST_DIV:  if (div_done) state_d = ST_FIX;
      ST_FIX:  state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  // Result only moves on accept, MUL or FIX, so it is frozen throughout DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= MD_MUL;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      result_q <= '0;
    end else if (accept) begin
      op_q    <= op;
      q_neg_q <= a_neg ^ b_neg;
      r_neg_q <= a_neg;
      if (md_is_div(op)) begin
        if (special) result_q <= special_res;
      end else if (MUL_REG == 0) begin
        result_q <= mul_pick(mul_src, op);
      end
    end else if (state_q == ST_MUL) begin
      result_q <= mul_pick(mul_src, op_q);
    end else if (state_q == ST_FIX) begin
      result_q <= fixed_res;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_prv32_muldiv_unit.sv
// tb/tb_prv32_muldiv_unit.sv - randomized self-checking bench against an arithmetic reference model
module tb_prv32_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, flush, out_ready;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        in_valid32, in_ready32, out_valid32, busy32;
  logic [31:0] result32;
  logic        in_valid16, in_ready16, out_valid16, busy16;
  logic [15:0] result16;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  prv32_muldiv_unit #(.XLEN(32), .MUL_REG(1)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32), .op(op),
    .a(a), .b(b), .flush(flush), .out_valid(out_valid32), .out_ready(out_ready),
    .result(result32), .busy(busy32)
  );

  prv32_muldiv_unit #(.XLEN(16), .MUL_REG(1)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16), .op(op),
    .a(a[15:0]), .b(b[15:0]), .flush(flush), .out_valid(out_valid16), .out_ready(out_ready),
    .result(result16), .busy(busy16)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference arithmetic on w-bit operands using wide signed integers.
  function automatic logic [31:0] model(input int w, input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    logic signed [127:0] ux, uy, sx, sy, p;
    logic [31:0] mask, minv;
    mask = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    minv = 32'h1 << (w - 1);
    ux = {96'b0, x & mask};
    uy = {96'b0, y & mask};
    sx = ux;
    sy = uy;
    if (ux[w-1]) sx = ux - (128'sd1 <<< w);
    if (uy[w-1]) sy = uy - (128'sd1 <<< w);
    case (f)
      3'd0: p = sx * sy;
      3'd1: p = (sx * sy) >>> w;
      3'd2: p = (sx * uy) >>> w;
      3'd3: p = (ux * uy) >>> w;
      3'd4: begin
        if (uy == 0) return mask;
        if (sx == -(128'sd1 <<< (w - 1)) && sy == -128'sd1) return minv;
        p = sx / sy;
      end
      3'd5: begin
        if (uy == 0) return mask;
        p = ux / uy;
      end
      3'd6: begin
        if (uy == 0) return x & mask;
        if (sx == -(128'sd1 <<< (w - 1)) && sy == -128'sd1) return 32'h0;
        p = sx % sy;
      end
      default: begin
        if (uy == 0) return x & mask;
        p = ux % uy;
      end
    endcase
    return p[31:0] & mask;
  endfunction

  function automatic int exp_latency(input int w, input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] mask, minv;
    mask = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    minv = 32'h1 << (w - 1);
    if (!f[2]) return 2;
    if ((y & mask) == 0) return 1;
    if (!f[0] && (x & mask) == minv && (y & mask) == mask) return 1;
    return w + 2;
  endfunction

  function automatic logic obs_valid(input int w);
    return (w == 16) ? out_valid16 : out_valid32;
  endfunction

  function automatic logic [31:0] obs_result(input int w);
    return (w == 16) ? {16'h0, result16} : result32;
  endfunction

  task automatic do_op(input int w, input logic [2:0] f, input logic [31:0] x, input logic [31:0] y, input string tag);
    int lat;
    @(negedge clk);
    op = f; a = x; b = y; out_ready = 1'b0;
    if (w == 16) in_valid16 = 1'b1; else in_valid32 = 1'b1;
    @(posedge clk); #1;
    in_valid16 = 1'b0; in_valid32 = 1'b0;
    a = $urandom; b = $urandom; op = 3'($urandom);
    lat = 1;
    while (!obs_valid(w) && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq({tag, "_lat"}, 32'(lat), 32'(exp_latency(w, f, x, y)));
    check_eq({tag, "_res"}, obs_result(w), model(w, f, x, y));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic wait_valid32(input string tag);
    int n;
    n = 0;
    while (!out_valid32 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq({tag, "_seen"}, {31'b0, out_valid32}, 32'h1);
  endtask

  initial begin
    logic        seen;
    logic [2:0]  f;
    logic [31:0] x, y;
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    in_valid32 = 1'b0; in_valid16 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst_in_ready", {31'b0, in_ready32}, 32'h1);
    check_eq("rst_out_valid", {31'b0, out_valid32}, 32'h0);
    check_eq("rst_busy", {31'b0, busy32}, 32'h0);
    check_eq("rst_result", result32, 32'h0);
    check_eq("rst_result16", {16'h0, result16}, 32'h0);

    do_op(32, 3'd0, 32'd7, 32'hFFFF_FFFD, "mul_7x-3");
    do_op(32, 3'd1, 32'h8000_0000, 32'h8000_0000, "mulh_min");
    do_op(32, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_ones");
    do_op(32, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_ones");
    do_op(32, 3'd4, 32'hFFFF_FFEC, 32'd3, "div_-20_3");
    do_op(32, 3'd6, 32'hFFFF_FFEC, 32'd3, "rem_-20_3");
    do_op(32, 3'd5, 32'd100, 32'd7, "divu_100_7");
    do_op(32, 3'd4, 32'h0000_1234, 32'd0, "div_by0");
    do_op(32, 3'd7, 32'h0000_1234, 32'd0, "remu_by0");
    do_op(32, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    do_op(32, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");

    // Flush mid-divide: the op vanishes and the unit is free the next cycle.
    @(negedge clk);
    op = 3'd4; a = 32'd1000; b = 32'd3; in_valid32 = 1'b1;
    @(posedge clk); #1;
    in_valid32 = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check_eq("flush_in_ready", {31'b0, in_ready32}, 32'h1);
    check_eq("flush_out_valid", {31'b0, out_valid32}, 32'h0);
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (out_valid32) seen = 1'b1; end
    check_eq("flush_no_out", {31'b0, seen}, 32'h0);
    do_op(32, 3'd0, 32'd3, 32'd5, "mul_after_flush");

    // Flush beats a same-cycle request in IDLE.
    @(negedge clk);
    op = 3'd0; a = 32'd2; b = 32'd2; in_valid32 = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid32 = 1'b0; flush = 1'b0;
    check_eq("idle_flush_ready", {31'b0, in_ready32}, 32'h1);
    check_eq("idle_flush_busy", {31'b0, busy32}, 32'h0);

    // Stall with out_ready low, then a request overlapping the handshake.
    @(negedge clk);
    op = 3'd0; a = 32'd6; b = 32'd7; in_valid32 = 1'b1;
    @(posedge clk); #1;
    in_valid32 = 1'b0;
    wait_valid32("stall");
    repeat (5) begin
      @(posedge clk); #1;
      check_eq("stall_valid", {31'b0, out_valid32}, 32'h1);
      check_eq("stall_result", result32, 32'd42);
    end
    check_eq("done_in_ready", {31'b0, in_ready32}, 32'h0);
    @(negedge clk);
    op = 3'd3; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; in_valid32 = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq("hs_not_accepted", {31'b0, in_ready32}, 32'h1);
    check_eq("hs_out_valid", {31'b0, out_valid32}, 32'h0);
    @(posedge clk); #1;
    in_valid32 = 1'b0;
    @(posedge clk); #1;
    check_eq("b2b_valid", {31'b0, out_valid32}, 32'h1);
    check_eq("b2b_result", result32, 32'hFFFF_FFFE);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Asynchronous reset mid-divide.
    @(negedge clk);
    op = 3'd4; a = 32'd12345; b = 32'd17; in_valid32 = 1'b1;
    @(posedge clk); #1;
    in_valid32 = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    check_eq("arst_out_valid", {31'b0, out_valid32}, 32'h0);
    check_eq("arst_in_ready", {31'b0, in_ready32}, 32'h1);
    check_eq("arst_busy", {31'b0, busy32}, 32'h0);
    check_eq("arst_result", result32, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (out_valid32) seen = 1'b1; end
    check_eq("arst_no_out", {31'b0, seen}, 32'h0);

    do_op(16, 3'd4, 32'h0000_FFFB, 32'd2, "div16_-5_2");
    do_op(16, 3'd6, 32'h0000_8000, 32'h0000_FFFF, "rem16_ovf");
    do_op(16, 3'd1, 32'h0000_8000, 32'h0000_8000, "mulh16_min");

    for (int i = 0; i < 200; i++) begin
      f = 3'($urandom); x = $urandom; y = $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'h0;
        1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        2: y = $urandom_range(1, 15);
        3: x = -$urandom_range(0, 1000);
        default: ;
      endcase
      do_op(32, f, x, y, "rand32");
    end
    for (int i = 0; i < 60; i++) begin
      f = 3'($urandom); x = $urandom & 32'hFFFF; y = $urandom & 32'hFFFF;
      case ($urandom_range(0, 5))
        0: y = 32'h0;
        1: begin x = 32'h8000; y = 32'hFFFF; end
        2: y = $urandom_range(1, 9);
        default: ;
      endcase
      do_op(16, f, x, y, "rand16");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
